// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module pipeline_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             mc_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MCW = $clog2(MC_TIMEOUT) + 1;
  localparam logic [MCW-1:0] TO_LAST = MCW'(MC_TIMEOUT - 1);
  localparam logic [MCW-1:0] CNT_ONE = MCW'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1
  } state_e;

  state_e         state_q, state_d;
  logic [MCW-1:0] mc_cnt_q, mc_cnt_d;
  logic           pend_q, pend_d;

  logic       in_wait;
  logic       mc_active;
  logic       flush_req;
  logic       to_hit;
  logic [5:0] stall_c;
  logic       flush_c;

  always_comb begin
    in_wait   = (state_q == ST_MC_WAIT);
    mc_active = (in_wait || ((state_q == ST_RUN) && ex_mc_start))
                && !ex_mc_done;
    to_hit    = in_wait && (mc_cnt_q == TO_LAST) && !ex_mc_done;
    flush_req = branch_taken || pend_q;
    stall_c   = 6'b000000;
    flush_c   = 1'b0;
    if (mem_busy) begin
      stall_c = 6'b011111;
    end else if (mc_active) begin
      stall_c = 6'b001111;
    end else if (flush_req) begin
      flush_c = 1'b1;
    end else if (stallreq_id) begin
      stall_c = 6'b000111;
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (ex_mc_start && !ex_mc_done) begin
          state_d  = ST_MC_WAIT;
          mc_cnt_d = CNT_ONE;
        end
      end
      ST_MC_WAIT: begin
        if (ex_mc_done || to_hit) begin
          state_d = ST_RUN;
        end else begin
          mc_cnt_d = mc_cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // A taken branch hidden behind a stall is remembered until it can squash
  always_comb begin
    pend_d = pend_q;
    if (flush_c) begin
      pend_d = 1'b0;
    end else if (branch_taken && (mem_busy || mc_active)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign stall      = rst ? stall_c : 6'b000000;
  assign flush      = rst & flush_c;
  assign mc_timeout = rst & to_hit;
  assign ctrl_state = state_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
